// File: rtl/mem_pkg.sv
// Shared definitions for the four-bank word-interleaved memory responder.
package mem_pkg;
    localparam int DEF_BANK_CYCLES  = 4;
    localparam int DEF_READ_LATENCY = 2;
    localparam int DEF_ROW_W        = 13;
    localparam int NUM_BANKS        = 4;
    localparam int DATA_W           = 16;
    localparam int ADDR_W           = 16;
    localparam int BANK_LO          = 1;
    localparam int BANK_HI          = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bank_state_e;

    function automatic logic [BANK_HI-BANK_LO:0] bank_of(input logic [ADDR_W-1:0] a);
        return a[BANK_HI:BANK_LO];
    endfunction
endpackage

// File: rtl/mem_bank.sv
// One memory bank: word array, IDLE/BUSY occupancy counter and read-sample register.
module mem_bank
    import mem_pkg::*;
#(
    parameter int BANK_CYCLES = DEF_BANK_CYCLES,
    parameter int ROW_W       = DEF_ROW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc,
    input  logic              we,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata
);
    localparam int CNT_W = $clog2(BANK_CYCLES);

    bank_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [2**ROW_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (acc) begin
                state_nxt = BUSY;
                cnt_nxt   = CNT_W'(BANK_CYCLES - 1);
            end
            BUSY: if (cnt == CNT_W'(1)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

    // Array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (acc && we)  mem[row] <= wdata;
        if (acc && !we) rdata    <= mem[row];
    end
endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank memory responder: decode, stall/err and the read return pipeline.
// Define MEM_ERR_STICKY_EN to make err hold until reset instead of pulsing.
module banked_mem_responder
    import mem_pkg::*;
#(
    parameter int BANK_CYCLES  = DEF_BANK_CYCLES,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int ROW_W        = DEF_ROW_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 stall,
    output logic                 err
);
    logic                              present, illegal, accept, rd_acc;
    logic [1:0]                        sel, sel_q;
    logic [ROW_W-1:0]                  row;
    logic [NUM_BANKS-1:0]              bank_busy;
    logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_rdata;
    logic [READ_LATENCY-1:0]           vld_pipe;
    logic [DATA_W-1:0]                 data_q;
    logic                              err_q;

    assign sel     = bank_of(addr);
    assign row     = addr[ROW_W+2:3];
    assign present = rd | wr;
    assign illegal = (rd & wr) | (present & addr[0]);
    assign stall   = present & ~illegal & bank_busy[sel];
    // Nothing is accepted while reset is asserted.
    assign accept  = present & ~illegal & ~bank_busy[sel] & ~rst;
    assign rd_acc  = accept & rd;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .BANK_CYCLES (BANK_CYCLES),
            .ROW_W       (ROW_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .acc   (accept && (sel == 2'(g))),
            .we    (wr),
            .row   (row),
            .wdata (data_in),
            .busy  (bank_busy[g]),
            .rdata (bank_rdata[g])
        );
    end

    // Bank holds the sampled word one cycle; the mux output is registered for the second.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[READ_LATENCY-2:0], rd_acc};
            sel_q    <= sel;
            data_q   <= vld_pipe[0] ? bank_rdata[sel_q] : '0;
`ifdef MEM_ERR_STICKY_EN
            err_q    <= err_q | illegal;
`else
            err_q    <= illegal;
`endif
        end
    end

    assign busy       = bank_busy;
    assign data_valid = vld_pipe[READ_LATENCY-1];
    assign data_out   = data_q;
    assign err        = err_q;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Scoreboard bench for banked_mem_responder with a cycle-level reference model.
module tb_banked_mem_responder;
    localparam int BC = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] addr = '0, data_in = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [15:0] data_out;
    logic        data_valid, stall, err;
    logic [3:0]  busy;

    always #5 clk = ~clk;

    banked_mem_responder #(.BANK_CYCLES(BC), .READ_LATENCY(2), .ROW_W(13)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .stall(stall), .err(err)
    );

    typedef struct {
        int          due;
        bit          known;
        logic [15:0] val;
    } exp_t;

    int          total = 0, bad = 0, cyc = 0;
    exp_t        sb[$];
    logic [15:0] mem_m [int];
    int          last_acc [4];
    bit          acc_vld [4];
    bit          err_exp = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, expv);
        end
    endtask

    // One bus cycle: drive, check combinational/registered status, advance the model.
    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic rs, output bit st);
        int       b;
        bit       pres, ill;
        logic [3:0] eb;
        @(negedge clk);
        rd = r; wr = w; addr = a; data_in = d; rst = rs;
        #1;
        b    = int'(a[2:1]);
        pres = r | w;
        ill  = (r & w) | (pres & a[0]);
        for (int k = 0; k < 4; k++)
            eb[k] = acc_vld[k] && (cyc - last_acc[k] >= 1) && (cyc - last_acc[k] <= BC - 1);
        st = pres && !ill && eb[b];
        chk("busy",  32'(busy),  32'(eb));
        chk("stall", 32'(stall), 32'(st));
        chk("err",   32'(err),   32'(err_exp));
        if (rs) begin
            for (int k = 0; k < 4; k++) acc_vld[k] = 1'b0;
            err_exp = 1'b0;
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        end else begin
            if (pres && !ill && !eb[b]) begin
                acc_vld[b]  = 1'b1;
                last_acc[b] = cyc;
                if (r) begin
                    exp_t e;
                    e.due   = cyc + 2;
                    e.known = mem_m.exists(int'(a[15:1]));
                    e.val   = e.known ? mem_m[int'(a[15:1])] : 16'h0;
                    sb.push_back(e);
                end else begin
                    mem_m[int'(a[15:1])] = d;
                end
            end
`ifdef MEM_ERR_STICKY_EN
            err_exp = err_exp | ill;
`else
            err_exp = ill;
`endif
        end
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, s);
    endtask

    // Monitor: pops the scoreboard whenever the DUT returns read data.
    always @(negedge clk) begin
        #3;
        if (mon_en) begin
            if (data_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_dv", 32'(data_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_due", 32'(cyc), 32'(e.due));
                    if (e.known) chk("rd_data", 32'(data_out), 32'(e.val));
                end
            end else begin
                chk("dv_idle", 32'(data_valid), 32'h0);
                chk("dout_idle", 32'(data_out), 32'h0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    chk("missing_dv", 32'(data_valid), 32'h1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bit          s, hold;
        int          n;
        logic        cr, cw;
        logic [15:0] ca, cd;
        logic [12:0] rw;
        cr = 1'b0; cw = 1'b0; ca = '0; cd = '0; hold = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dv",   32'(data_valid), 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_err",  32'(err), 32'h0);
        mon_en = 1'b1;

        // write then read same bank
        step(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, s);
        idle(3);
        step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, s);
        idle(6);

        // bank conflict, requester holds until accepted
        step(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, s);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'h000A, 16'h0, 1'b0, s);
            if (!s) break;
            n++;
        end
        chk("conflict_stalls", 32'(n), 32'(BC - 1));
        idle(6);

        // interleave across all four banks
        step(1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, s);
        step(1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0, s);
        step(1'b0, 1'b1, 16'h0004, 16'h3333, 1'b0, s);
        step(1'b0, 1'b1, 16'h0006, 16'h4444, 1'b0, s);
        idle(4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(2 * i), 16'h0, 1'b0, s);
        idle(6);

        // illegal requests
        step(1'b1, 1'b1, 16'h0020, 16'h0, 1'b0, s);
        idle(1);
        step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, s);
        idle(4);

        // reset mid-read, then immediate re-access of the same bank
        step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, s);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, s);
        step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, s);
        chk("rst_reaccept_stall", 32'(s), 32'h0);
        idle(6);

        // max row and aliasing neighbours
        step(1'b0, 1'b1, 16'h0008, 16'h1234, 1'b0, s);
        idle(4);
        step(1'b0, 1'b1, 16'hFFF8, 16'h5A5A, 1'b0, s);
        idle(4);
        step(1'b1, 1'b0, 16'hFFF8, 16'h0, 1'b0, s);
        idle(4);
        step(1'b1, 1'b0, 16'h0008, 16'h0, 1'b0, s);
        idle(6);

        // randomized traffic with hold-and-retry on stall
        for (int i = 0; i < 500; i++) begin
            if (!(hold && $urandom_range(0, 3) != 0)) begin
                case ($urandom_range(0, 3))
                    0: rw = 13'h0000;
                    1: rw = 13'h0001;
                    2: rw = 13'h1FFF;
                    default: rw = 13'h0155;
                endcase
                ca = {rw, 2'($urandom_range(0, 3)), 1'b0};
                if ($urandom_range(0, 15) == 0) ca[0] = 1'b1;
                cd = 16'($urandom);
                case ($urandom_range(0, 9))
                    0: begin cr = 1'b0; cw = 1'b0; end
                    1: begin cr = 1'b1; cw = 1'b1; end
                    2, 3, 4: begin cr = 1'b0; cw = 1'b1; end
                    default: begin cr = 1'b1; cw = 1'b0; end
                endcase
            end
            if ($urandom_range(0, 79) == 0) begin
                step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, s);
                hold = 1'b0;
            end else begin
                step(cr, cw, ca, cd, 1'b0, s);
                hold = s;
            end
        end
        idle(6);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/banked_mem_responder.md
Name: banked_mem_responder

Overview:
- Memory-side responder for the cache controller's memory port: a four-bank, word-interleaved 16-bit data memory.
- Accepts single-word rd/wr requests.
- Per-bank busy status and combinational stall give the controller back-pressure.
- Read data returns after a fixed latency.
- Sits between the cache FSM's memory-request outputs and the backing store; the cache FSM's memory inputs consume `data_out`, `busy`, `stall` and `err`.

Parameters:
- BANK_CYCLES, 4, cycles a bank is occupied per accepted access (min 2).
- READ_LATENCY, 2, cycles from read acceptance to `data_out` valid (fixed 2; other values unsupported).
- ROW_W, 13, row-address bits per bank; each bank holds 2^ROW_W 16-bit words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  16  byte address; bank = addr[2:1]; row = addr[ROW_W+2:3]; addr[0] must be 0.
- data_in  in  16  write data.
- wr  in  1  write request, single-cycle qualified.
- rd  in  1  read request, single-cycle qualified.
- data_out  out  16  read data, valid only when data_valid=1, else 16'h0000.
- data_valid  out  1  one-cycle pulse marking returned read data.
- busy  out  4  busy[b]=1 while bank b is occupied.
- stall  out  1  combinational: request present to a busy bank, request not accepted.
- err  out  1  one-cycle pulse: the previous cycle's request was illegal and dropped.

Behaviour:
- Reset (sync, active-high): all busy counters 0, busy=0, read pipeline cleared, data_valid=0, data_out=0, err=0. Array contents are not reset and are unspecified until written.
- Request present = rd|wr.
- Illegal request = (rd&wr) | ((rd|wr)&addr[0]).
  - Illegal requests are not performed and do not occupy a bank.
  - stall=0 for them.
  - err=1 in the next cycle for exactly one cycle.
- stall = (rd|wr) & ~illegal & busy[addr[2:1]]. A stalled request is ignored entirely; the requester holds it and retries.
- Acceptance at cycle T requires a present, legal request to a non-busy bank.
- Each bank has a 2-state machine, IDLE and BUSY, with a down-counter:
  - IDLE → BUSY on acceptance; counter loads BANK_CYCLES-1.
  - BUSY decrements each cycle and returns to IDLE when the counter reaches 1.
  - busy[b] is high for cycles T+1 … T+BANK_CYCLES-1.
  - A new access to bank b can be accepted at T+BANK_CYCLES-1+1.
- Accesses to different banks are independent. Only one request port exists, so one acceptance per cycle.
- Write: the array is updated at the edge ending cycle T. A read accepted at any later cycle returns the new data.
- Read:
  - The array word is sampled at cycle T.
  - It is presented on data_out with data_valid=1 in cycle T+2 only.
  - Pipelined reads to different banks on consecutive cycles return on consecutive cycles, in order.
- Reset asserted mid-access: pending read data is discarded (no data_valid), all banks return to IDLE the next cycle, and an in-flight write already committed stays committed.
- Address bits above ROW_W+2 are ignored; addresses alias and wrap.

Optional Feature:
- MEM_ERR_STICKY_EN
  - Defined: err, once set, stays 1 until rst.
  - Not defined: err is a one-cycle pulse per illegal request.
  - Request handling is identical either way.

Decomposition:
- Shared package mem_pkg holds:
  - BANK_CYCLES and READ_LATENCY defaults.
  - Bank state encoding (IDLE=1'b0, BUSY=1'b1).
  - Bank-select field positions (BANK_LO=1, BANK_HI=2).
- One natural sub-module, mem_bank, instantiated 4×. It contains the ROW_W-deep array, the busy state machine/counter and the read-sample register. The top holds decode, stall/err logic and the output pipeline/mux.

Test Plan:
- Write then read, same bank: wr addr=16'h0010 data=16'hBEEF at T0.
  - busy=4'b0000 at T0; busy[0]=1 at T1–T3.
  - rd addr=16'h0010 at T4 → data_out=16'hBEEF, data_valid=1 at T6.
- Bank conflict: rd addr=16'h0002 at T0, rd addr=16'h000A at T1 → stall=1 at T1–T3, accepted at T4, data_valid at T2 and T6.
- Interleave: rd to addr 16'h0000, 0002, 0004, 0006 on T0–T3 → stall=0 throughout, busy walks 0001→0011→0111→1111, data_valid=1 at T2–T5 with words in request order.
- Illegal: rd=wr=1 at T0, then rd addr=16'h0003 at T2 → err=1 at T1 and T3, stall=0, busy unchanged, no data_valid. With MEM_ERR_STICKY_EN, err stays 1 from T1 until rst.
- Reset mid-read: rd accepted at T0, rst=1 at T1 → T2: busy=0, data_valid=0, data_out=16'h0000; a new rd to the same bank at T2 is accepted without stall.
- Aliasing: wr addr=16'h0008 data=16'h1234, later rd same → 16'h1234. Max row: wr addr=16'hFFF8 data=16'h5A5A, rd → 16'h5A5A, and addr 16'h0008 remains 16'h1234.
